// File: rtl/cache_pkg.sv
// Shared definitions for the cache flush walker: FSM state encoding and
// the helper that locates the last way of a set.
package cache_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_CHECK = 3'd2,
      ST_WB    = 3'd3,
      ST_CLEAR = 3'd4,
      ST_DONE  = 3'd5
   } flush_state_t;

   // Index of the highest way; its bit in the one-hot way marks the set carry.
   function automatic int last_way(input int ways);
      return ways - 1;
   endfunction

endpackage

// File: rtl/flush_ctr.sv
// Set/way walk counter. The way is one-hot and rotates left on every
// advance. Leaving the top way carries into the set index. The set index
// wraps naturally because NUMLINES is a power of two.
module flush_ctr
   import cache_pkg::*;
#(
   parameter int NUMWAYS  = 4,
   parameter int NUMLINES = 128,
   parameter int SETLEN   = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               advance,
   output logic [SETLEN-1:0]  FlushAdr,
   output logic [NUMWAYS-1:0] FlushWay,
   output logic               LastLine
);

   localparam int                LASTWAY = last_way(NUMWAYS);
   localparam logic [SETLEN-1:0] LASTSET = SETLEN'(NUMLINES - 1);

   logic way_wrap;

   assign way_wrap = FlushWay[LASTWAY];
   assign LastLine = way_wrap & (FlushAdr == LASTSET);

   // Step way-major within a set; the set index moves only on the way wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         FlushAdr <= '0;
         FlushWay <= NUMWAYS'(1);
      end else if (advance) begin
         FlushWay <= {FlushWay[NUMWAYS-2:0], FlushWay[LASTWAY]};
         if (way_wrap) FlushAdr <= FlushAdr + 1'b1;
      end
   end

endmodule

// File: rtl/cache_flush_walker.sv
// Flush sequencer. On a flush request it visits every (set, way). Each
// dirty line is written back and then has its dirty bit cleared. The
// pipeline is stalled for the whole walk, and a single FlushDone pulse
// marks the end. All outputs are decoded from the registered state, so
// no request input reaches a bus or array control combinationally.
module cache_flush_walker
   import cache_pkg::*;
#(
   parameter int NUMWAYS  = 4,
   parameter int NUMLINES = 128,
   parameter int SETLEN   = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               FlushCache,
   input  logic               FlushStage,
   input  logic               LineDirty,
   input  logic               CacheBusAck,
   output logic [SETLEN-1:0]  FlushAdr,
   output logic [NUMWAYS-1:0] FlushWay,
   output logic               FlushActive,
   output logic               CacheWriteLine,
   output logic               ClearDirty,
   output logic               FlushStall,
   output logic               FlushDone
);

   flush_state_t state, next_state;
   logic         advance;
   logic         last_line;

   // Step past a line once it is known clean, or once its dirty bit is cleared.
   assign advance = ((state == ST_CHECK) & ~LineDirty) | (state == ST_CLEAR);

   flush_ctr #(
      .NUMWAYS  (NUMWAYS),
      .NUMLINES (NUMLINES),
      .SETLEN   (SETLEN)
   ) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .advance  (advance),
      .FlushAdr (FlushAdr),
      .FlushWay (FlushWay),
      .LastLine (last_line)
   );

   // State register; reset abandons any walk or writeback in flight.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // Walk sequencing. FlushStage gates only the start of a walk.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (FlushCache & ~FlushStage) next_state = ST_READ;
         ST_READ:  next_state = ST_CHECK;
         ST_CHECK: begin
            if (LineDirty)      next_state = ST_WB;
            else if (last_line) next_state = ST_DONE;
            else                next_state = ST_READ;
         end
         ST_WB:    if (CacheBusAck) next_state = ST_CLEAR;
         ST_CLEAR: next_state = last_line ? ST_DONE : ST_READ;
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   assign FlushActive    = (state == ST_READ) | (state == ST_CHECK) |
                           (state == ST_WB)   | (state == ST_CLEAR);
   assign FlushStall     = FlushActive;
   assign CacheWriteLine = (state == ST_WB);
   assign ClearDirty     = (state == ST_CLEAR);
   assign FlushDone      = (state == ST_DONE);

endmodule

// File: tb/tb_cache_flush_walker.sv
// Bench for cache_flush_walker. A small dirty-array model and a bus model
// surround the DUT. Stimulus pushes the expected writeback and clear
// lines and done cycles into queues. A negedge monitor pops and compares
// them as the DUT produces ClearDirty, CacheWriteLine and FlushDone.
module tb_cache_flush_walker;

   localparam int NW = 4;
   localparam int NL = 128;
   localparam int SL = 7;

   typedef struct packed {
      logic [SL-1:0] adr;
      logic [NW-1:0] way;
   } line_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          FlushCache = 1'b0;
   logic          FlushStage = 1'b0;
   logic          LineDirty;
   logic          CacheBusAck = 1'b0;
   logic [SL-1:0] FlushAdr;
   logic [NW-1:0] FlushWay;
   logic          FlushActive, CacheWriteLine, ClearDirty, FlushStall, FlushDone;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int tot_stall = 0;
   int tot_wl = 0;
   int wb_cnt = 0;
   int ack_delay = 0;
   bit ack_hold = 1'b0;
   logic wl_q = 1'b0;

   logic [NL-1:0][NW-1:0] dirty_mem;
   logic [NL-1:0][NW-1:0] load_val;
   logic                  load_req = 1'b0;

   line_t exp_clr[$];
   line_t exp_wb[$];
   int    exp_done[$];
   line_t mon_e;
   int    mon_d;

   cache_flush_walker #(.NUMWAYS(NW), .NUMLINES(NL), .SETLEN(SL)) dut (
      .clk            (clk),
      .reset          (reset),
      .FlushCache     (FlushCache),
      .FlushStage     (FlushStage),
      .LineDirty      (LineDirty),
      .CacheBusAck    (CacheBusAck),
      .FlushAdr       (FlushAdr),
      .FlushWay       (FlushWay),
      .FlushActive    (FlushActive),
      .CacheWriteLine (CacheWriteLine),
      .ClearDirty     (ClearDirty),
      .FlushStall     (FlushStall),
      .FlushDone      (FlushDone)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Dirty array model with a registered read, plus the cycle counter.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (load_req) dirty_mem <= load_val;
      else if (ClearDirty) dirty_mem[FlushAdr] <= dirty_mem[FlushAdr] & ~FlushWay;
      LineDirty <= |(dirty_mem[FlushAdr] & FlushWay);
   end

   // Bus model: ack after ack_delay writeback cycles, or held high throughout.
   always @(negedge clk) begin
      if (CacheWriteLine) begin
         CacheBusAck = ack_hold || (wb_cnt >= ack_delay);
         wb_cnt <= wb_cnt + 1;
      end else begin
         CacheBusAck = ack_hold;
         wb_cnt <= 0;
      end
   end

   // Monitor: compare DUT events against the scoreboard queues.
   always @(negedge clk) begin
      wl_q <= CacheWriteLine;
      if (FlushStall) tot_stall <= tot_stall + 1;
      if (CacheWriteLine) tot_wl <= tot_wl + 1;
      check("active_eq_stall", 32'(FlushActive), 32'(FlushStall));
      if (ClearDirty) begin
         if (exp_clr.size() == 0) begin
            tests++; fails++;
            $display("FAIL clr_unexpected: got adr %0d way %b expected none", FlushAdr, FlushWay);
         end else begin
            mon_e = exp_clr.pop_front();
            check("clr_line", 32'({FlushAdr, FlushWay}), 32'(mon_e));
         end
      end
      if (CacheWriteLine && !wl_q) begin
         if (exp_wb.size() == 0) begin
            tests++; fails++;
            $display("FAIL wb_unexpected: got adr %0d way %b expected none", FlushAdr, FlushWay);
         end else begin
            mon_e = exp_wb.pop_front();
            check("wb_line", 32'({FlushAdr, FlushWay}), 32'(mon_e));
         end
      end
      if (FlushDone) begin
         if (exp_done.size() == 0) begin
            tests++; fails++;
            $display("FAIL done_unexpected: got pulse at %0d expected none", cyc);
         end else begin
            mon_d = exp_done.pop_front();
            check("done_cycle", 32'(cyc), 32'(mon_d));
            check("done_adr", 32'(FlushAdr), 32'd0);
            check("done_way", 32'(FlushWay), 32'd1);
            check("done_stall", 32'(FlushStall), 32'd0);
         end
      end
   end

   task automatic load(input logic [NL-1:0][NW-1:0] v);
      load_val = v;
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   // One full flush. The request stays high through DONE, and the first
   // IDLE cycle after it must not restart the walk.
   task automatic run_flush(input string name, input int exp_len, input int exp_wbc,
                            input bit stage_during);
      int t0, s0, w0;
      bit seen;
      t0 = cyc; s0 = tot_stall; w0 = tot_wl;
      exp_done.push_back(t0 + exp_len);
      FlushCache = 1'b1;
      FlushStage = 1'b0;
      @(negedge clk);
      check({name, "_start"}, 32'(FlushStall), 32'd1);
      if (stage_during) FlushStage = 1'b1;
      seen = FlushDone;
      for (int n = 0; n < exp_len + 100 && !seen; n++) begin
         @(negedge clk);
         seen = FlushDone;
      end
      if (!seen) begin
         tests++; fails++;
         $display("FAIL %s_timeout: got no FlushDone expected at cycle %0d", name, t0 + exp_len);
      end
      FlushStage = 1'b0;
      check({name, "_stall_cycles"}, 32'(tot_stall - s0), 32'(exp_len - 1));
      check({name, "_wb_cycles"}, 32'(tot_wl - w0), 32'(exp_wbc));
      @(negedge clk);
      check({name, "_post_done_idle"}, 32'({FlushStall, FlushDone}), 32'd0);
      FlushCache = 1'b0;
      @(negedge clk);
      check({name, "_no_restart"}, 32'(FlushStall), 32'd0);
      check({name, "_clr_left"}, 32'(exp_clr.size()), 32'd0);
      check({name, "_wb_left"}, 32'(exp_wb.size()), 32'd0);
   endtask

   initial begin
      logic [NL-1:0][NW-1:0] pat;
      line_t e;
      bit seen;

      // Reset state
      pat = '0;
      load(pat);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_adr", 32'(FlushAdr), 32'd0);
      check("rst_way", 32'(FlushWay), 32'd1);
      check("rst_outs", 32'({FlushActive, CacheWriteLine, ClearDirty, FlushStall, FlushDone}), 32'd0);

      // All lines clean
      run_flush("clean", 1025, 0, 1'b0);

      // FlushStage blocks the start only; raising it mid-walk has no effect
      FlushCache = 1'b1;
      FlushStage = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stage_block", 32'(FlushStall), 32'd0);
      end
      run_flush("stage", 1025, 0, 1'b1);

      // Single dirty line at set 3 way 1, ack three cycles after WB begins
      pat = '0;
      pat[3][1] = 1'b1;
      load(pat);
      ack_hold = 1'b0;
      ack_delay = 3;
      e.adr = SL'(3); e.way = 4'b0010;
      exp_wb.push_back(e);
      exp_clr.push_back(e);
      run_flush("one_dirty", 1030, 4, 1'b0);

      // Wrap boundaries: set 0 way 3 -> set 1 way 0, and the final line
      pat = '0;
      pat[0][3] = 1'b1;
      pat[1][0] = 1'b1;
      pat[127][3] = 1'b1;
      load(pat);
      ack_hold = 1'b1;
      e.adr = SL'(0);   e.way = 4'b1000; exp_wb.push_back(e); exp_clr.push_back(e);
      e.adr = SL'(1);   e.way = 4'b0001; exp_wb.push_back(e); exp_clr.push_back(e);
      e.adr = SL'(127); e.way = 4'b1000; exp_wb.push_back(e); exp_clr.push_back(e);
      run_flush("wrap", 1031, 3, 1'b0);

      // Every line dirty, ack held high: four cycles per line
      pat = '1;
      load(pat);
      for (int s = 0; s < NL; s++)
         for (int w = 0; w < NW; w++) begin
            e.adr = SL'(s);
            e.way = NW'(1 << w);
            exp_wb.push_back(e);
            exp_clr.push_back(e);
         end
      run_flush("all_dirty", 2049, 512, 1'b0);

      // Reset in the middle of a writeback at set 5 way 2
      pat = '0;
      pat[5][2] = 1'b1;
      load(pat);
      ack_hold = 1'b0;
      ack_delay = 100000;
      e.adr = SL'(5); e.way = 4'b0100;
      exp_wb.push_back(e);
      FlushCache = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 1200 && !seen; n++) begin
         @(negedge clk);
         seen = CacheWriteLine;
      end
      check("midwb_reached", 32'(seen), 32'd1);
      check("midwb_line", 32'({FlushAdr, FlushWay}), 32'({7'd5, 4'b0100}));
      repeat (3) @(negedge clk);
      check("midwb_held", 32'(CacheWriteLine), 32'd1);
      reset = 1'b1;
      FlushCache = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check("midwb_rst_adr", 32'(FlushAdr), 32'd0);
      check("midwb_rst_way", 32'(FlushWay), 32'd1);
      check("midwb_rst_outs", 32'({FlushActive, CacheWriteLine, ClearDirty, FlushStall, FlushDone}), 32'd0);
      repeat (4) @(negedge clk);
      check("midwb_stays_idle", 32'({FlushStall, CacheWriteLine}), 32'd0);
      check("midwb_done_left", 32'(exp_done.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cache_flush_walker.md
Name: cache_flush_walker

Overview:
- Sequencer that walks every (set, way) of a set-associative cache on a flush request.
- Writes back each dirty line, then clears its dirty bit.
- Drives the flush address/way into the cache address-select mux, upstream of the replacement and dirty/valid arrays.
- Stalls the pipeline until the whole walk completes, then pulses FlushDone.

Parameters:
- NUMWAYS, 4, number of ways; power of two, ≥2.
- NUMLINES, 128, number of sets per way; power of two.
- SETLEN, 7, set index width; equals log2(NUMLINES).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- FlushCache  in  1  flush request level; held by requester until FlushDone
- FlushStage  in  1  pipeline kill; blocks a flush from starting
- LineDirty  in  1  dirty bit of line at FlushAdr/FlushWay; valid one cycle after address presented (registered array read)
- CacheBusAck  in  1  bus has accepted and completed the line writeback
- FlushAdr  out  SETLEN  set index being walked
- FlushWay  out  NUMWAYS  one-hot way being walked
- FlushActive  out  1  selects FlushAdr in the cache address mux
- CacheWriteLine  out  1  line writeback request, held until ack
- ClearDirty  out  1  one-cycle pulse clearing the dirty bit at FlushAdr/FlushWay
- FlushStall  out  1  stall pipeline
- FlushDone  out  1  one-cycle completion pulse

Behaviour:
- Reset, applied on clk edge and valid in any state:
  - state IDLE, FlushAdr=0, FlushWay=1 (way 0).
  - All other outputs 0.
  - Any in-flight writeback is abandoned; no ClearDirty is issued.
- States: IDLE, READ, CHECK, WB, CLEAR, DONE.
- IDLE → READ when FlushCache & ~FlushStage. Otherwise stay in IDLE. The counters are already 0/way0.
- READ (1 cycle): address/way presented to the arrays. → CHECK.
- CHECK (1 cycle): LineDirty sampled.
  - Dirty → WB.
  - Clean → advance counters, then → READ, or → DONE if the line was the last.
- WB: CacheWriteLine=1 every cycle. Stay until CacheBusAck=1, then → CLEAR.
- CLEAR (1 cycle): ClearDirty=1 with the same FlushAdr/FlushWay. Advance counters, then → READ, or → DONE if the line was the last.
- Advance order: way-major inside set.
  - FlushWay rotates left one bit.
  - When moving from way NUMWAYS-1 to way 0, FlushAdr increments.
  - The last line is FlushAdr=NUMLINES-1 with FlushWay[NUMWAYS-1]. After it, counters wrap to 0/way0 and the state goes to DONE.
- DONE (1 cycle): FlushDone=1, FlushStall=0. → IDLE unconditionally.
  - FlushCache still high during DONE is ignored.
  - A new flush needs FlushCache sampled in IDLE.
- FlushStall=1 and FlushActive=1 in READ, CHECK, WB, CLEAR. Both are 0 in IDLE and DONE.
- FlushStage only gates the start. Once in READ it is ignored and the walk always completes.
- CacheBusAck outside WB is ignored.
- An ack in the first WB cycle is accepted, giving a minimum WB length of 1.
- Latency:
  - Clean line: 2 cycles.
  - Dirty line: 4 + ack wait cycles.
  - All-clean flush: FlushDone asserted 2·NUMWAYS·NUMLINES + 1 cycles after the start cycle.
- Outputs are registered-state decoded. There is no combinational path from FlushCache to CacheWriteLine or ClearDirty.

Decomposition:
- cache_pkg:
  - flush-walker state enum (IDLE..DONE).
  - Helper constant for last way index.
- Sub-module flush_ctr (set/way counter):
  - Inputs: clk, reset, advance.
  - Outputs: FlushAdr, FlushWay one-hot, LastLine.
  - Rotate-and-carry logic.
- The walker FSM instantiates flush_ctr and decodes the outputs.

Test Plan:
1. Reset mid-WB (set 5, way 2), then reset high one cycle → next cycle state IDLE, FlushAdr=0, FlushWay=4'b0001, CacheWriteLine=0, ClearDirty never pulses.
2. All lines clean, FlushCache high at cycle 0 → FlushStall high cycles 1..1024, FlushDone pulse exactly at cycle 1025, FlushAdr back to 0 (NUMWAYS=4, NUMLINES=128).
3. Only (set 3, way 1) dirty, ack 3 cycles after CacheWriteLine rises → CacheWriteLine high exactly while FlushAdr=3/FlushWay=4'b0010; then one ClearDirty pulse at the same address; total +5 cycles vs all-clean.
4. FlushCache & FlushStage both high in IDLE for 4 cycles → no start, FlushStall=0. FlushStage dropping → READ the next cycle. FlushStage high during the walk → no effect.
5. CacheBusAck held high continuously, all lines dirty → each dirty line takes exactly 4 cycles; 512 ClearDirty pulses; FlushDone at cycle 2049.
6. Wrap boundary: observe transition from set 0 way 3 to set 1 way 0 and the final line set 127 way 3 → FlushAdr increments only on way wrap; DONE follows the last line; FlushCache held through DONE does not restart.
